rcv_block: RTL and testbench
============================

Name: rcv_block

Overview:
UART-style serial receiver. Detects a start bit on serial_in and samples 8 data bits LSB-first plus one stop bit at a fixed oversampling rate. Valid bytes go into a holding register with data_ready, framing/overrun status and an even-parity bit. It sits between the asynchronous serial pin and a byte-oriented consumer that acknowledges with data_read.

Parameters:
BIT_PERIOD, 10, clock cycles per serial bit; nominal 2.5 ns clock gives a 25 ns bit; must tolerate ±4% bit-period error.
DATA_BITS, 8, data bits per frame; fixed at 8 for this block.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  reset; asynchronous, active-low.
serial_in  input  1  asynchronous serial line, idle high.
data_read  input  1  consumer acknowledge, one-cycle pulse, synchronous to clk.
rx_data  output  8  last successfully received byte.
data_ready  output  1  rx_data holds an unread byte.
overrun_error  output  1  new byte arrived while previous byte was still unread.
framing_error  output  1  last frame had stop bit = 0.
even_parity_bit  output  1  XOR of all rx_data bits; total ones in {rx_data, bit} is even.

Behaviour:
- Clock and reset: one clock; asynchronous active-low reset.
- Reset values: rx_data=8'hFF, data_ready=0, overrun_error=0, framing_error=0, even_parity_bit=0; FSM in IDLE; synchronizer flops =1.
- Input: serial_in passes through a 2-flop synchronizer. Start detection is a 1->0 transition on the synchronized signal.
- FSM states:
  - IDLE: on start edge, clear framing_error and go to START_CHK.
  - START_CHK: wait BIT_PERIOD/2 cycles. If line is still 0, go to RECEIVE. If line is 1, treat as a glitch and return to IDLE with no output change.
  - RECEIVE: sample once every BIT_PERIOD cycles, at mid-bit. Shift each sample into the MSB of an 8-bit shift register, so data is LSB-first. After 8 samples go to STOP_CHK.
  - STOP_CHK: sample after a further BIT_PERIOD cycles. If 1, go to LOAD. If 0, set framing_error=1; rx_data and data_ready are unchanged; return to IDLE.
  - LOAD: one cycle. Load rx_data from the shift register and set data_ready=1. If data_ready was already 1 and not cleared this same cycle, set overrun_error=1. Return to IDLE.
- Outputs update at most 3 cycles after the stop-bit sample point. They are stable well before 2 bit periods after the stop bit ends.
- even_parity_bit = ^rx_data, driven combinationally from the register.
- data_read: a one-cycle pulse clears data_ready and overrun_error on the next rising edge. framing_error is not cleared by data_read; it clears only at the next start edge or on reset.
- If data_read and LOAD occur in the same cycle, LOAD wins: data_ready=1 and overrun_error is not set.
- A new start edge may be accepted in IDLE immediately after LOAD or STOP_CHK, allowing back-to-back frames.
- Reset mid-frame aborts the frame and returns everything to reset values.

Decomposition:
- Package rcv_pkg: FSM state enum (IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD), BIT_PERIOD, DATA_BITS.
- Sub-module bit_timer: counter producing a half-period strobe and full-period sample strobes plus a bit count. Enabled by the FSM, cleared on the start edge.
- Synchronizer, shift register and output registers stay in rcv_block.

Test Plan:
- Reset with idle line -> rx_data=FF, data_ready=0, framing_error=0, overrun_error=0, even_parity_bit=0.
- Send 8'b11110000, stop=1, 25 ns bit; check 2 bit periods after frame end -> rx_data=F0, data_ready=1, framing_error=0, overrun_error=0, parity=0. Then pulse data_read -> data_ready=0 one cycle later.
- Send 8'b01010100 with bit period 24 ns (fast) and again with 26 ns (slow) -> rx_data=54, data_ready=1, parity=1, no errors.
- Send 8'b11010011 with stop=0 after reset -> framing_error=1, data_ready=0, rx_data=FF. Then a good frame 8'b11010010 -> rx_data=D2, framing_error=0, data_ready=1, parity=0.
- Send two good frames (AA then 55) without data_read -> rx_data=55, data_ready=1, overrun_error=1. A data_read pulse clears both.
- Glitch: serial_in low for 2 cycles only -> no state change, outputs unchanged.

Source files
------------

// File: rtl/rcv_pkg.sv
`timescale 1ns/1ps
// rcv_pkg: shared constants and FSM state type
// for the rcv_block serial receiver.
package rcv_pkg;

    localparam int BIT_PERIOD = 10;
    localparam int DATA_BITS  = 8;

    // FSM reaches START_CHK two to three cycles after the pin falls
    // (sync flops + edge detect), so one cycle is trimmed from the
    // half-bit wait to keep later samples near mid-bit.
    localparam int START_WAIT = BIT_PERIOD / 2 - 1;

    localparam int CNT_W  = $clog2(BIT_PERIOD);
    localparam int BITS_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECEIVE,
        STOP_CHK,
        LOAD
    } rcv_state_t;

endpackage

// File: rtl/rcv_block_bit_timer.sv
`timescale 1ns/1ps
// bit_timer: bit-period counter giving one half-bit strobe
// after a clear, then a strobe every full bit, plus a bit count.
module bit_timer
    import rcv_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              enable,
    output logic              half_tick,
    output logic              bit_tick,
    output logic [BITS_W-1:0] bit_cnt
);

    logic [CNT_W-1:0] cnt;
    logic             first;

    assign half_tick = enable & first &
                       (cnt == CNT_W'(START_WAIT - 1));
    assign bit_tick  = enable & ~first &
                       (cnt == CNT_W'(BIT_PERIOD - 1));

    // Count cycles; restart on each strobe and on clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt     <= '0;
            first   <= 1'b1;
            bit_cnt <= '0;
        end else if (clear) begin
            cnt     <= '0;
            first   <= 1'b1;
            bit_cnt <= '0;
        end else if (enable) begin
            if (half_tick) begin
                cnt   <= '0;
                first <= 1'b0;
            end else if (bit_tick) begin
                cnt     <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcv_block.sv
`timescale 1ns/1ps
// rcv_block: UART-style receiver, 8 data bits LSB-first,
// one stop bit, byte holding register with status flags.
module rcv_block
    import rcv_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 even_parity_bit
);

    logic sync_meta;
    logic sync_line;
    logic line_q;
    logic start_edge;

    rcv_state_t state;
    rcv_state_t state_nxt;

    logic tmr_clear;
    logic tmr_en;
    logic half_tick;
    logic bit_tick;
    logic [BITS_W-1:0] bit_cnt;

    logic [DATA_BITS-1:0] shift_q;
    logic shift_en;
    logic frame_err_set;
    logic load_en;

    assign start_edge      = line_q & ~sync_line;
    assign even_parity_bit = ^rx_data;

    bit_timer u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (tmr_clear),
        .enable    (tmr_en),
        .half_tick (half_tick),
        .bit_tick  (bit_tick),
        .bit_cnt   (bit_cnt)
    );

    // Two-flop synchronizer plus delayed copy for edge detect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_q    <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            sync_line <= sync_meta;
            line_q    <= sync_line;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt     = state;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;
        shift_en      = 1'b0;
        frame_err_set = 1'b0;
        load_en       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    tmr_clear = 1'b1;
                    state_nxt = START_CHK;
                end
            end
            START_CHK: begin
                tmr_en = 1'b1;
                if (half_tick)
                    state_nxt = sync_line ? IDLE : RECEIVE;
            end
            RECEIVE: begin
                tmr_en = 1'b1;
                if (bit_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BITS_W'(DATA_BITS - 1))
                        state_nxt = STOP_CHK;
                end
            end
            STOP_CHK: begin
                tmr_en = 1'b1;
                if (bit_tick) begin
                    if (sync_line) begin
                        state_nxt = LOAD;
                    end else begin
                        frame_err_set = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            LOAD: begin
                load_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mid-bit samples enter at the MSB so bit 0 ends up at LSB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        shift_q <= '0;
        else if (shift_en) shift_q <= {sync_line, shift_q[DATA_BITS-1:1]};
    end

    // Holding register; LOAD takes priority over a same-cycle read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else if (load_en) begin
            rx_data    <= shift_q;
            data_ready <= 1'b1;
            if (data_read)       overrun_error <= 1'b0;
            else if (data_ready) overrun_error <= 1'b1;
        end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

    // Framing flag lives until the next start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)             framing_error <= 1'b0;
        else if (tmr_clear)     framing_error <= 1'b0;
        else if (frame_err_set) framing_error <= 1'b1;
    end

endmodule

// File: tb/tb_rcv_block.sv
`timescale 1ns/1ps
// tb_rcv_block: directed serial frames into rcv_block;
// expectations are queued with a due time and checked by a monitor.
module tb_rcv_block;

    localparam realtime CLK_HALF = 1.25;

    logic       tb_clk    = 1'b0;
    logic       n_rst     = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_read = 1'b0;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;
    logic       even_parity_bit;

    typedef struct {
        string      name;
        realtime    due;
        logic [7:0] data;
        logic       rdy;
        logic       ovr;
        logic       frm;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   passed = 0;

    rcv_block dut (
        .clk             (tb_clk),
        .n_rst           (n_rst),
        .serial_in       (serial_in),
        .data_read       (data_read),
        .rx_data         (rx_data),
        .data_ready      (data_ready),
        .overrun_error   (overrun_error),
        .framing_error   (framing_error),
        .even_parity_bit (even_parity_bit)
    );

    always #(CLK_HALF) tb_clk = ~tb_clk;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, want);
    endtask

    // Compare every expectation whose due time has arrived.
    always @(negedge tb_clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= $realtime) begin
            cur = exp_q.pop_front();
            check({cur.name, " rx_data"}, rx_data, cur.data);
            check({cur.name, " data_ready"}, {7'd0, data_ready},
                  {7'd0, cur.rdy});
            check({cur.name, " overrun"}, {7'd0, overrun_error},
                  {7'd0, cur.ovr});
            check({cur.name, " framing"}, {7'd0, framing_error},
                  {7'd0, cur.frm});
            check({cur.name, " parity"}, {7'd0, even_parity_bit},
                  {7'd0, cur.par});
        end
    end

    task automatic push_exp(input string nm, input realtime dly,
                            input logic [7:0] d, input logic r,
                            input logic o, input logic f,
                            input logic p);
        exp_t e;
        e.name = nm;
        e.due  = $realtime + dly;
        e.data = d;
        e.rdy  = r;
        e.ovr  = o;
        e.frm  = f;
        e.par  = p;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input realtime bt);
        serial_in = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            #(bt);
        end
        serial_in = stop;
        #(bt);
        serial_in = 1'b1;
    endtask

    task automatic pulse_read(input string nm, input logic [7:0] d,
                              input logic p);
        @(negedge tb_clk);
        data_read = 1'b1;
        @(negedge tb_clk);
        data_read = 1'b0;
        push_exp(nm, 2.5, d, 1'b0, 1'b0, 1'b0, p);
        #10;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_rst     = 1'b0;
        serial_in = 1'b1;
        repeat (5) @(negedge tb_clk);
        n_rst = 1'b1;
        push_exp("reset", 0, 8'hFF, 0, 0, 0, 0);
        repeat (4) @(negedge tb_clk);

        send_frame(8'hF0, 1'b1, 25);
        push_exp("f0", 50, 8'hF0, 1, 0, 0, 0);
        #55;
        pulse_read("f0_read", 8'hF0, 0);

        send_frame(8'h54, 1'b1, 24);
        push_exp("54_fast", 48, 8'h54, 1, 0, 0, 1);
        #55;
        pulse_read("54_fast_read", 8'h54, 1);

        send_frame(8'h54, 1'b1, 26);
        push_exp("54_slow", 52, 8'h54, 1, 0, 0, 1);
        #55;
        pulse_read("54_slow_read", 8'h54, 1);

        @(negedge tb_clk);
        n_rst = 1'b0;
        repeat (3) @(negedge tb_clk);
        n_rst = 1'b1;
        push_exp("reset2", 0, 8'hFF, 0, 0, 0, 0);
        repeat (4) @(negedge tb_clk);

        send_frame(8'hD3, 1'b0, 25);
        push_exp("d3_badstop", 50, 8'hFF, 0, 0, 1, 0);
        #55;

        send_frame(8'hD2, 1'b1, 25);
        push_exp("d2_good", 50, 8'hD2, 1, 0, 0, 0);
        #55;
        pulse_read("d2_read", 8'hD2, 0);

        send_frame(8'hAA, 1'b1, 25);
        push_exp("aa", 50, 8'hAA, 1, 0, 0, 0);
        #55;
        send_frame(8'h55, 1'b1, 25);
        push_exp("55_overrun", 50, 8'h55, 1, 1, 0, 0);
        #55;
        pulse_read("55_read", 8'h55, 0);

        @(negedge tb_clk);
        serial_in = 1'b0;
        repeat (2) @(negedge tb_clk);
        serial_in = 1'b1;
        push_exp("glitch", 100, 8'h55, 0, 0, 0, 0);
        #105;

        send_frame(8'h3C, 1'b1, 25);
        #5;
        serial_in = 1'b0;
        #75;
        @(negedge tb_clk);
        n_rst = 1'b0;
        push_exp("mid_reset", 5, 8'hFF, 0, 0, 0, 0);
        #10;
        serial_in = 1'b1;
        @(negedge tb_clk);
        n_rst = 1'b1;
        push_exp("after_reset", 300, 8'hFF, 0, 0, 0, 0);
        #305;

        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge tb_clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
